pipeline_ctrl: RTL and testbench

//  Stall/flush scheduler for the 5-stage pipeline. Drives write enables and bubble/flush selects for
//  PC, IF/ID, ID/EX, EX/MEM and MEM/WB from ID-stage hazard checks and the data-memory handshake.
//  ID/EX bubble = zeroing of its WB/M/EX control inputs (mux outside this block).

---
 rtl/pipe_ctrl_pkg.sv | 30 +++
 rtl/pipeline_ctrl_hazard_detect.sv | 37 +++
 rtl/pipeline_ctrl.sv | 131 +++++++++++++
 tb/tb_pipeline_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush scheduler: FSM state encoding and
// the bundle of register write enables and bubble/flush selects it drives.
package pipe_ctrl_pkg;

    localparam int DEF_REG_W = 5;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_HALT     = 2'b10
    } state_t;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_write;
        logic idex_bubble;
        logic exmem_write;
        logic memwb_bubble;
    } ctl_t;

    // Field order: pc_write, ifid_write, ifid_flush, idex_write, idex_bubble, exmem_write, memwb_bubble
    localparam ctl_t CTL_PASS   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    localparam ctl_t CTL_STALL  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    localparam ctl_t CTL_FLUSH  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    localparam ctl_t CTL_FREEZE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    localparam ctl_t CTL_RESET  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// ID-stage hazard compare: load-use and branch-operand hazards against the
// instructions in EX and MEM. Register 0 never creates a dependence.
module hazard_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W = DEF_REG_W
) (
    input  logic [REG_W-1:0] ifid_rs_i,
    input  logic [REG_W-1:0] ifid_rt_i,
    input  logic             ifid_uses_rt_i,
    input  logic             ifid_branch_i,
    input  logic             idex_memread_i,
    input  logic             idex_regwrite_i,
    input  logic [REG_W-1:0] idex_rd_i,
    input  logic             exmem_memread_i,
    input  logic [REG_W-1:0] exmem_rd_i,
    output logic             lu_o,
    output logic             br_o,
    output logic             stall_id_o
);

    logic ex_match;
    logic mem_match;

    always_comb begin
        ex_match  = (idex_rd_i != '0) &&
                    ((idex_rd_i == ifid_rs_i) || (ifid_uses_rt_i && (idex_rd_i == ifid_rt_i)));
        mem_match = (exmem_rd_i != '0) &&
                    ((exmem_rd_i == ifid_rs_i) || (ifid_uses_rt_i && (exmem_rd_i == ifid_rt_i)));
        lu_o       = idex_memread_i && ex_match;
        // A branch compared in ID needs operands that forwarding cannot supply yet.
        br_o       = ifid_branch_i &&
                     ((idex_regwrite_i && ex_match) || (exmem_memread_i && mem_match));
        stall_id_o = lu_o || br_o;
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline freeze/flush scheduler: combines ID hazards, control-flow redirects
// and the data-memory handshake into stage write enables and bubble selects.
module pipeline_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W       = DEF_REG_W,
    parameter int CNT_W       = 16,
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = 5
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [REG_W-1:0] ifid_rs_i,
    input  logic [REG_W-1:0] ifid_rt_i,
    input  logic             ifid_uses_rt_i,
    input  logic             ifid_branch_i,
    input  logic             branch_taken_i,
    input  logic             jump_i,
    input  logic             idex_memread_i,
    input  logic             idex_regwrite_i,
    input  logic [REG_W-1:0] idex_rd_i,
    input  logic             exmem_memread_i,
    input  logic [REG_W-1:0] exmem_rd_i,
    input  logic             dmem_req_i,
    input  logic             dmem_ack_i,
    output logic             pc_write_o,
    output logic             ifid_write_o,
    output logic             ifid_flush_o,
    output logic             idex_write_o,
    output logic             idex_bubble_o,
    output logic             exmem_write_o,
    output logic             memwb_bubble_o,
    output logic [1:0]       state_o,
    output logic             err_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    state_t          state;
    logic [TO_W-1:0] wait_cnt;
    logic            lu;
    logic            br;
    logic            stall_id;
    logic            mem_miss;
    ctl_t            run_ctl;
    ctl_t            ctl;

    hazard_detect #(.REG_W(REG_W)) u_hazard (
        .ifid_rs_i       (ifid_rs_i),
        .ifid_rt_i       (ifid_rt_i),
        .ifid_uses_rt_i  (ifid_uses_rt_i),
        .ifid_branch_i   (ifid_branch_i),
        .idex_memread_i  (idex_memread_i),
        .idex_regwrite_i (idex_regwrite_i),
        .idex_rd_i       (idex_rd_i),
        .exmem_memread_i (exmem_memread_i),
        .exmem_rd_i      (exmem_rd_i),
        .lu_o            (lu),
        .br_o            (br),
        .stall_id_o      (stall_id)
    );

    // Data-memory handshake: a request is outstanding while dmem_req_i is high;
    // dmem_ack_i high completes it in that same cycle (data valid). A request
    // without ack freezes every stage up to EX/MEM and bubbles MEM/WB.
    assign mem_miss = dmem_req_i && !dmem_ack_i;

    always_comb begin
        if (stall_id)
            run_ctl = CTL_STALL;
        else if (branch_taken_i || jump_i)
            run_ctl = CTL_FLUSH;
        else
            run_ctl = CTL_PASS;
    end

    always_comb begin
        ctl = CTL_FREEZE;
        if (!rst_i) begin
            ctl = CTL_RESET;
        end else begin
            case (state)
                ST_RUN:      ctl = mem_miss   ? CTL_FREEZE : run_ctl;
                ST_MEM_WAIT: ctl = dmem_ack_i ? run_ctl    : CTL_FREEZE;
                default:     ctl = CTL_FREEZE;
            endcase
        end
    end

    assign pc_write_o     = ctl.pc_write;
    assign ifid_write_o   = ctl.ifid_write;
    assign ifid_flush_o   = ctl.ifid_flush;
    assign idex_write_o   = ctl.idex_write;
    assign idex_bubble_o  = ctl.idex_bubble;
    assign exmem_write_o  = ctl.exmem_write;
    assign memwb_bubble_o = ctl.memwb_bubble;
    assign state_o        = state;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state       <= ST_RUN;
            wait_cnt    <= '0;
            err_o       <= 1'b0;
            stall_cnt_o <= '0;
        end else begin
            if (!ctl.pc_write && (stall_cnt_o != '1))
                stall_cnt_o <= stall_cnt_o + CNT_W'(1);
            case (state)
                ST_RUN: begin
                    if (mem_miss) begin
                        state    <= ST_MEM_WAIT;
                        wait_cnt <= TO_W'(1);
                    end
                end
                ST_MEM_WAIT: begin
                    // An ack arriving on the timeout cycle still completes the access.
                    if (dmem_ack_i) begin
                        state    <= ST_RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == TO_W'(MEM_TIMEOUT)) begin
                        state <= ST_HALT;
                        err_o <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + TO_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: vector table, random hazard mix against a small
// model, and hand-written memory-wait / timeout / reset sequences.
module tb_pipeline_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic [4:0] ifid_rs_i, ifid_rt_i, idex_rd_i, exmem_rd_i;
    logic       ifid_uses_rt_i, ifid_branch_i, branch_taken_i, jump_i;
    logic       idex_memread_i, idex_regwrite_i, exmem_memread_i, dmem_req_i, dmem_ack_i;
    logic       pc_write_o, ifid_write_o, ifid_flush_o, idex_write_o, idex_bubble_o;
    logic       exmem_write_o, memwb_bubble_o, err_o;
    logic [1:0] state_o;
    logic [1:0] stall_cnt_o;

    localparam logic [6:0] C_PASS   = 7'b1101010;
    localparam logic [6:0] C_STALL  = 7'b0001110;
    localparam logic [6:0] C_FLUSH  = 7'b1111010;
    localparam logic [6:0] C_FREEZE = 7'b0000001;
    localparam logic [6:0] C_RESET  = 7'b0011111;

    typedef struct {
        string      name;
        logic [4:0] rs, rt;
        logic       urt, br, tk, jp, lmr, rw;
        logic [4:0] rd;
        logic       xmr;
        logic [4:0] xrd;
        logic       req, ack;
        logic [6:0] exp_ctl;
    } vec_t;

    vec_t        tbl[$];
    logic [9:0]  exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    pipeline_ctrl #(.REG_W(5), .CNT_W(2), .MEM_TIMEOUT(4), .TO_W(3)) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .ifid_rs_i       (ifid_rs_i),
        .ifid_rt_i       (ifid_rt_i),
        .ifid_uses_rt_i  (ifid_uses_rt_i),
        .ifid_branch_i   (ifid_branch_i),
        .branch_taken_i  (branch_taken_i),
        .jump_i          (jump_i),
        .idex_memread_i  (idex_memread_i),
        .idex_regwrite_i (idex_regwrite_i),
        .idex_rd_i       (idex_rd_i),
        .exmem_memread_i (exmem_memread_i),
        .exmem_rd_i      (exmem_rd_i),
        .dmem_req_i      (dmem_req_i),
        .dmem_ack_i      (dmem_ack_i),
        .pc_write_o      (pc_write_o),
        .ifid_write_o    (ifid_write_o),
        .ifid_flush_o    (ifid_flush_o),
        .idex_write_o    (idex_write_o),
        .idex_bubble_o   (idex_bubble_o),
        .exmem_write_o   (exmem_write_o),
        .memwb_bubble_o  (memwb_bubble_o),
        .state_o         (state_o),
        .err_o           (err_o),
        .stall_cnt_o     (stall_cnt_o)
    );

    // Clock and reset
    always #5 clk_i = ~clk_i;

    // Scoreboard compare
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Driver tasks
    task automatic clear_inputs();
        ifid_rs_i = '0; ifid_rt_i = '0; ifid_uses_rt_i = 1'b0; ifid_branch_i = 1'b0;
        branch_taken_i = 1'b0; jump_i = 1'b0; idex_memread_i = 1'b0; idex_regwrite_i = 1'b0;
        idex_rd_i = '0; exmem_memread_i = 1'b0; exmem_rd_i = '0;
        dmem_req_i = 1'b0; dmem_ack_i = 1'b0;
    endtask

    task automatic drive(input vec_t v);
        ifid_rs_i = v.rs; ifid_rt_i = v.rt; ifid_uses_rt_i = v.urt; ifid_branch_i = v.br;
        branch_taken_i = v.tk; jump_i = v.jp; idex_memread_i = v.lmr; idex_regwrite_i = v.rw;
        idex_rd_i = v.rd; exmem_memread_i = v.xmr; exmem_rd_i = v.xrd;
        dmem_req_i = v.req; dmem_ack_i = v.ack;
    endtask

    // Push expectation, sample on the falling edge, then step past the next rising edge.
    task automatic cycle(input string name, input logic [9:0] exp);
        logic [9:0] got;
        logic [9:0] e;
        exp_q.push_back(exp);
        @(negedge clk_i);
        got = {pc_write_o, ifid_write_o, ifid_flush_o, idex_write_o, idex_bubble_o,
               exmem_write_o, memwb_bubble_o, state_o, err_o};
        e = exp_q.pop_front();
        chk(name, 32'(got), 32'(e));
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset(input string name);
        rst_i = 1'b0;
        @(posedge clk_i);
        #1;
        cycle(name, {C_RESET, 2'b00, 1'b0});
        chk({name, "_cnt"}, 32'(stall_cnt_o), 32'd0);
        rst_i = 1'b1;
    endtask

    function automatic logic m(input logic [4:0] r, input logic [4:0] rs,
                               input logic [4:0] rt, input logic urt);
        return (r != 5'd0) && ((r == rs) || (urt && (r == rt)));
    endfunction

    initial begin
        logic [6:0] ectl;
        logic       lu_m, br_m;
        logic [1:0] cnt_m;
        vec_t       v;

        // name, rs, rt, urt, br, tk, jp, lmr, rw, rd, xmr, xrd, req, ack, expected
        tbl.push_back('{"idle",        5'd0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0,  1'b0, 1'b0, C_PASS});
        tbl.push_back('{"lu_rs",       5'd8, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0,  1'b0, 1'b0, C_STALL});
        tbl.push_back('{"lu_rt",       5'd3, 5'd8,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0,  1'b0, 1'b0, C_STALL});
        tbl.push_back('{"lu_rt_unused",5'd3, 5'd8,  1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0,  1'b0, 1'b0, C_PASS});
        tbl.push_back('{"lu_r0",       5'd0, 5'd0,  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0,  1'b0, 1'b0, C_PASS});
        tbl.push_back('{"alu_br",      5'd9, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0, 5'd0,  1'b0, 1'b0, C_STALL});
        tbl.push_back('{"alu_nobr",    5'd9, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0, 5'd0,  1'b0, 1'b0, C_PASS});
        tbl.push_back('{"ldmem_br",    5'd9, 5'd0,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd9,  1'b0, 1'b0, C_STALL});
        tbl.push_back('{"ldmem_nobr",  5'd9, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd9,  1'b0, 1'b0, C_PASS});
        tbl.push_back('{"taken",       5'd4, 5'd5,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd6, 1'b1, 5'd7,  1'b0, 1'b0, C_FLUSH});
        tbl.push_back('{"jump",        5'd0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0,  1'b0, 1'b0, C_FLUSH});
        tbl.push_back('{"stall_taken", 5'd9, 5'd0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd9, 1'b0, 5'd0,  1'b0, 1'b0, C_STALL});
        tbl.push_back('{"req_ack",     5'd0, 5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0,  1'b1, 1'b1, C_PASS});
        tbl.push_back('{"req_ack_tk",  5'd0, 5'd0,  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0,  1'b1, 1'b1, C_FLUSH});
        tbl.push_back('{"rt_ldmem_br", 5'd1, 5'd12, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd12, 1'b0, 1'b0, C_STALL});
        tbl.push_back('{"jump_lu",     5'd8, 5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 5'd8, 1'b0, 5'd0,  1'b0, 1'b0, C_STALL});

        clear_inputs();
        do_reset("reset");

        // Table: 7 stall rows push the 2-bit counter into saturation.
        foreach (tbl[i]) begin
            drive(tbl[i]);
            cycle(tbl[i].name, {tbl[i].exp_ctl, 2'b00, 1'b0});
        end
        chk("table_cnt_sat", 32'(stall_cnt_o), 32'd3);

        // Load-use: one stall then clear.
        clear_inputs();
        do_reset("rst_lu");
        ifid_rs_i = 5'd8; idex_memread_i = 1'b1; idex_rd_i = 5'd8;
        cycle("lu_stall", {C_STALL, 2'b00, 1'b0});
        clear_inputs();
        cycle("lu_clear", {C_PASS, 2'b00, 1'b0});
        chk("lu_cnt", 32'(stall_cnt_o), 32'd1);

        // Load feeding a branch: stall with load in EX, again with it in MEM.
        do_reset("rst_brld");
        ifid_branch_i = 1'b1; ifid_rs_i = 5'd9;
        idex_memread_i = 1'b1; idex_regwrite_i = 1'b1; idex_rd_i = 5'd9;
        cycle("brld_ex", {C_STALL, 2'b00, 1'b0});
        idex_memread_i = 1'b0; idex_regwrite_i = 1'b0; idex_rd_i = 5'd0;
        exmem_memread_i = 1'b1; exmem_rd_i = 5'd9;
        cycle("brld_mem", {C_STALL, 2'b00, 1'b0});
        exmem_memread_i = 1'b0; exmem_rd_i = 5'd0;
        cycle("brld_go", {C_PASS, 2'b00, 1'b0});
        chk("brld_cnt", 32'(stall_cnt_o), 32'd2);

        // Memory ack after three frozen cycles.
        clear_inputs();
        do_reset("rst_mem");
        dmem_req_i = 1'b1;
        cycle("mem_miss", {C_FREEZE, 2'b00, 1'b0});
        cycle("mem_wait1", {C_FREEZE, 2'b01, 1'b0});
        cycle("mem_wait2", {C_FREEZE, 2'b01, 1'b0});
        dmem_ack_i = 1'b1;
        cycle("mem_ack", {C_PASS, 2'b01, 1'b0});
        clear_inputs();
        cycle("mem_run", {C_PASS, 2'b00, 1'b0});
        chk("mem_cnt", 32'(stall_cnt_o), 32'd3);

        // Ack on the timeout cycle wins.
        do_reset("rst_ackwin");
        dmem_req_i = 1'b1;
        cycle("aw_miss", {C_FREEZE, 2'b00, 1'b0});
        for (int k = 0; k < 3; k++) cycle("aw_wait", {C_FREEZE, 2'b01, 1'b0});
        dmem_ack_i = 1'b1; branch_taken_i = 1'b1;
        cycle("aw_ack", {C_FLUSH, 2'b01, 1'b0});
        clear_inputs();
        cycle("aw_run", {C_PASS, 2'b00, 1'b0});

        // Timeout into HALT, sticky error, exit only by reset.
        do_reset("rst_to");
        dmem_req_i = 1'b1;
        cycle("to_miss", {C_FREEZE, 2'b00, 1'b0});
        for (int k = 0; k < 4; k++) cycle("to_wait", {C_FREEZE, 2'b01, 1'b0});
        cycle("to_halt", {C_FREEZE, 2'b10, 1'b1});
        dmem_ack_i = 1'b1;
        cycle("halt_ack", {C_FREEZE, 2'b10, 1'b1});
        clear_inputs(); jump_i = 1'b1;
        cycle("halt_jump", {C_FREEZE, 2'b10, 1'b1});
        chk("halt_cnt", 32'(stall_cnt_o), 32'd3);
        do_reset("halt_reset");
        clear_inputs();
        cycle("post_halt", {C_PASS, 2'b00, 1'b0});

        // Reset in the middle of a memory wait.
        do_reset("rst_mid");
        dmem_req_i = 1'b1;
        cycle("mid_miss", {C_FREEZE, 2'b00, 1'b0});
        cycle("mid_wait", {C_FREEZE, 2'b01, 1'b0});
        do_reset("mid_reset");
        clear_inputs();
        cycle("mid_run", {C_PASS, 2'b00, 1'b0});

        // Random hazard mix in RUN against a small model.
        do_reset("rst_rand");
        cnt_m = 2'd0;
        for (int k = 0; k < 48; k++) begin
            v = '{"rand", 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                  1'b0, 1'b0, C_PASS};
            lu_m = v.lmr && m(v.rd, v.rs, v.rt, v.urt);
            br_m = v.br && ((v.rw && m(v.rd, v.rs, v.rt, v.urt)) || (v.xmr && m(v.xrd, v.rs, v.rt, v.urt)));
            if (lu_m || br_m) ectl = C_STALL;
            else if (v.tk || v.jp) ectl = C_FLUSH;
            else ectl = C_PASS;
            drive(v);
            cycle("rand", {ectl, 2'b00, 1'b0});
            if (!ectl[6] && cnt_m != 2'd3) cnt_m = cnt_m + 2'd1;
            chk("rand_cnt", 32'(stall_cnt_o), 32'(cnt_m));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
